// File: rtl/load_align_unit_if.sv
// Request, memory and result signals of the load alignment unit.
// The master side issues loads and models the data memory; the slave side is the unit.
interface load_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_signed;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_misalign;

  modport master (
    output req_valid, req_addr, req_size, req_signed, mem_valid, mem_rdata,
    input  req_ready, mem_rd, mem_addr, load_valid, load_data, load_misalign
  );

  modport slave (
    input  req_valid, req_addr, req_size, req_signed, mem_valid, mem_rdata,
    output req_ready, mem_rd, mem_addr, load_valid, load_data, load_misalign
  );
endinterface

// File: rtl/load_align_unit.sv
// Load alignment unit: issues one or two word reads per load, then extracts and
// zero/sign-extends the addressed byte/half/word/double. All outputs are registered.
module load_align_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int SPLIT_EN = 1
) (
  input logic              clk,
  input logic              reset,
  load_align_unit_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int OB = $clog2(NB);
  localparam int SW = $clog2(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} state_t;

  state_t            state_r, state_s;
  logic [OB-1:0]     off_r;
  logic [1:0]        size_r;
  logic              signed_r;
  logic              span_r;
  logic [DATA_W-1:0] word0_r;
  logic              req_ready_r, req_ready_s;
  logic              mem_rd_r, mem_rd_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic              load_valid_r, load_valid_s;
  logic [DATA_W-1:0] load_data_r, load_data_s;
  logic              load_mis_r, load_mis_s;
  logic              acc_s;
  logic [OB-1:0]     req_off_s;
  logic [3:0]        req_bytes_s;
  logic              req_mis_s, req_span_s, req_reject_s;

  // Shift the two-word window down to the addressed byte, then mask and extend.
  function automatic logic [DATA_W-1:0] extract(input logic [2*DATA_W-1:0] cat,
                                                input logic [OB-1:0] off,
                                                input logic [1:0] size,
                                                input logic sgn);
    logic [2*DATA_W-1:0] sh;
    logic [6:0]          nbits;
    logic [DATA_W-1:0]   mask;
    logic                sbit;
    sh    = cat >> {off, 3'b000};
    nbits = 7'd8 << size;
    mask  = ~({DATA_W{1'b1}} << nbits);
    sbit  = sgn & sh[SW'(nbits - 7'd1)];
    return (sh[DATA_W-1:0] & mask) | (sbit ? ~mask : {DATA_W{1'b0}});
  endfunction

  // Decode the incoming request: offset, misalignment, word-span and legality.
  always_comb begin
    req_off_s    = bus.req_addr[OB-1:0];
    req_bytes_s  = 4'd1 << bus.req_size;
    req_mis_s    = ((4'(req_off_s) & (req_bytes_s - 4'd1)) != 4'd0);
    req_span_s   = ((5'(req_off_s) + 5'(req_bytes_s)) > 5'(NB));
    req_reject_s = ((bus.req_size == 2'b11) && (DATA_W == 32)) ||
                   (req_mis_s && (SPLIT_EN == 0));
  end

  // Next state and next registered output values.
  always_comb begin
    state_s      = state_r;
    acc_s        = 1'b0;
    mem_rd_s     = 1'b0;
    mem_addr_s   = mem_addr_r;
    load_valid_s = 1'b0;
    load_data_s  = load_data_r;
    load_mis_s   = load_mis_r;
    case (state_r)
      IDLE: begin
        if (bus.req_valid) begin
          acc_s = 1'b1;
          if (req_reject_s) begin
            state_s      = DONE;
            load_valid_s = 1'b1;
            load_data_s  = {DATA_W{1'b0}};
            load_mis_s   = 1'b1;
          end else begin
            state_s    = RD0;
            mem_rd_s   = 1'b1;
            mem_addr_s = {bus.req_addr[ADDR_W-1:OB], {OB{1'b0}}};
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD0: begin
        mem_rd_s = 1'b1;
        if (bus.mem_valid && span_r) begin
          state_s    = RD1;
          mem_addr_s = mem_addr_r + ADDR_W'(NB);
        end else if (bus.mem_valid) begin
          state_s      = DONE;
          mem_rd_s     = 1'b0;
          load_valid_s = 1'b1;
          load_data_s  = extract({{DATA_W{1'b0}}, bus.mem_rdata}, off_r, size_r, signed_r);
          load_mis_s   = 1'b0;
        end else begin
          state_s = RD0;
        end
      end
      RD1: begin
        mem_rd_s = 1'b1;
        if (bus.mem_valid) begin
          state_s      = DONE;
          mem_rd_s     = 1'b0;
          load_valid_s = 1'b1;
          load_data_s  = extract({bus.mem_rdata, word0_r}, off_r, size_r, signed_r);
          load_mis_s   = 1'b0;
        end else begin
          state_s = RD1;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    req_ready_s = (state_s == IDLE);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request capture, first-word capture and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      off_r        <= {OB{1'b0}};
      size_r       <= 2'b00;
      signed_r     <= 1'b0;
      span_r       <= 1'b0;
      word0_r      <= {DATA_W{1'b0}};
      req_ready_r  <= 1'b1;
      mem_rd_r     <= 1'b0;
      mem_addr_r   <= {ADDR_W{1'b0}};
      load_valid_r <= 1'b0;
      load_data_r  <= {DATA_W{1'b0}};
      load_mis_r   <= 1'b0;
    end else begin
      if (acc_s) begin
        off_r    <= req_off_s;
        size_r   <= bus.req_size;
        signed_r <= bus.req_signed;
        span_r   <= req_span_s;
      end
      if ((state_r == RD0) && bus.mem_valid) begin
        word0_r <= bus.mem_rdata;
      end
      req_ready_r  <= req_ready_s;
      mem_rd_r     <= mem_rd_s;
      mem_addr_r   <= mem_addr_s;
      load_valid_r <= load_valid_s;
      load_data_r  <= load_data_s;
      load_mis_r   <= load_mis_s;
    end
  end

  assign bus.req_ready     = req_ready_r;
  assign bus.mem_rd        = mem_rd_r;
  assign bus.mem_addr      = mem_addr_r;
  assign bus.load_valid    = load_valid_r;
  assign bus.load_data     = load_data_r;
  assign bus.load_misalign = load_mis_r;
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: one instance with split reads (u1) and
// one that flags misaligned loads (u0), both against a zero-wait memory model.
module tb_load_align_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic        force_valid = 1'b0;
  logic [31:0] mem100 = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;

  logic [31:0] got_data;
  logic        got_mis;
  logic        got_ready;
  int          got_lat;
  int          got_nrd;
  int          got_rdc;
  logic [31:0] got_a [4];

  always #5 clk = ~clk;

  load_align_unit_if #(.DATA_W(32), .ADDR_W(32)) if1 ();
  load_align_unit_if #(.DATA_W(32), .ADDR_W(32)) if0 ();

  load_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1)) u1 (.clk(clk), .reset(reset), .bus(if1.slave));
  load_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(0)) u0 (.clk(clk), .reset(reset), .bus(if0.slave));

  function automatic logic [31:0] memrd(input logic [31:0] a, input logic [31:0] m100);
    case (a)
      32'h0000_0100: return m100;
      32'h0000_0200: return 32'h4433_2211;
      32'h0000_0204: return 32'h8877_6655;
      32'hFFFF_FFFC: return 32'hAABB_CCDD;
      32'h0000_0000: return 32'h1122_3344;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign if1.mem_rdata = memrd(if1.mem_addr, mem100);
  assign if0.mem_rdata = memrd(if0.mem_addr, mem100);
  assign if1.mem_valid = force_valid | (if1.mem_rd & ~hold);
  assign if0.mem_valid = force_valid | (if0.mem_rd & ~hold);

  task automatic run_load(input bit use0, input logic [31:0] addr, input logic [1:0] size, input logic sgn);
    int lat;
    got_nrd = 0;
    got_rdc = 0;
    for (int i = 0; i < 4; i++) got_a[i] = 32'hFFFF_FFFF;
    @(negedge clk);
    got_ready = use0 ? if0.req_ready : if1.req_ready;
    if (use0) begin
      if0.req_valid = 1'b1; if0.req_addr = addr; if0.req_size = size; if0.req_signed = sgn;
    end else begin
      if1.req_valid = 1'b1; if1.req_addr = addr; if1.req_size = size; if1.req_signed = sgn;
    end
    @(negedge clk);
    if0.req_valid = 1'b0;
    if1.req_valid = 1'b0;
    lat = 1;
    while (!(use0 ? if0.load_valid : if1.load_valid) && lat < 40) begin
      if (use0 ? if0.mem_rd : if1.mem_rd) got_rdc++;
      if (use0 ? (if0.mem_rd && if0.mem_valid) : (if1.mem_rd && if1.mem_valid)) begin
        if (got_nrd < 4) got_a[got_nrd] = use0 ? if0.mem_addr : if1.mem_addr;
        got_nrd++;
      end
      @(negedge clk);
      lat++;
    end
    got_lat  = lat;
    got_data = use0 ? if0.load_data : if1.load_data;
    got_mis  = use0 ? if0.load_misalign : if1.load_misalign;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if ({if1.req_ready, if1.mem_rd, if1.load_valid, if1.load_misalign} !== 4'b1000) begin n_fail++; $display("FAIL reset_ctl_u1: got %b expected 1000", {if1.req_ready, if1.mem_rd, if1.load_valid, if1.load_misalign}); end
    n_checks++; if ({if1.mem_addr, if1.load_data} !== 64'h0) begin n_fail++; $display("FAIL reset_data_u1: got %h expected 0", {if1.mem_addr, if1.load_data}); end
    n_checks++; if ({if0.req_ready, if0.mem_rd, if0.load_valid, if0.load_misalign} !== 4'b1000) begin n_fail++; $display("FAIL reset_ctl_u0: got %b expected 1000", {if0.req_ready, if0.mem_rd, if0.load_valid, if0.load_misalign}); end
    reset = 1'b0;
  endtask

  task automatic test_byte();
    mem100 = 32'h8BAD_F00D;
    run_load(1'b0, 32'h103, 2'b00, 1'b1);
    n_checks++; if (got_data !== 32'hFFFF_FF8B) begin n_fail++; $display("FAIL byte_signed: got %h expected FFFFFF8B", got_data); end
    n_checks++; if (got_mis !== 1'b0) begin n_fail++; $display("FAIL byte_signed_mis: got %b expected 0", got_mis); end
    n_checks++; if (got_nrd !== 1 || got_a[0] !== 32'h100) begin n_fail++; $display("FAIL byte_reads: got %0d reads at %h expected 1 at 00000100", got_nrd, got_a[0]); end
    n_checks++; if (got_lat !== 2) begin n_fail++; $display("FAIL byte_latency: got %0d expected 2", got_lat); end
    run_load(1'b0, 32'h103, 2'b00, 1'b0);
    n_checks++; if (got_data !== 32'h0000_008B) begin n_fail++; $display("FAIL byte_unsigned: got %h expected 0000008B", got_data); end
    n_checks++; if (got_mis !== 1'b0) begin n_fail++; $display("FAIL byte_unsigned_mis: got %b expected 0", got_mis); end
  endtask

  task automatic test_half();
    mem100 = 32'h8000_1234;
    run_load(1'b0, 32'h102, 2'b01, 1'b1);
    n_checks++; if (got_data !== 32'hFFFF_8000) begin n_fail++; $display("FAIL half_signed: got %h expected FFFF8000", got_data); end
    run_load(1'b0, 32'h100, 2'b01, 1'b0);
    n_checks++; if (got_data !== 32'h0000_1234) begin n_fail++; $display("FAIL half_unsigned: got %h expected 00001234", got_data); end
  endtask

  task automatic test_split();
    run_load(1'b0, 32'h203, 2'b10, 1'b0);
    n_checks++; if (got_data !== 32'h7766_5544) begin n_fail++; $display("FAIL split_word: got %h expected 77665544", got_data); end
    n_checks++; if (got_nrd !== 2 || got_a[0] !== 32'h200 || got_a[1] !== 32'h204) begin n_fail++; $display("FAIL split_reads: got %0d reads at %h %h expected 2 at 00000200 00000204", got_nrd, got_a[0], got_a[1]); end
    n_checks++; if (got_lat !== 3) begin n_fail++; $display("FAIL split_latency: got %0d expected 3", got_lat); end
    run_load(1'b0, 32'h203, 2'b01, 1'b1);
    n_checks++; if (got_data !== 32'h0000_5544) begin n_fail++; $display("FAIL split_half: got %h expected 00005544", got_data); end
    run_load(1'b0, 32'hFFFF_FFFE, 2'b10, 1'b0);
    n_checks++; if (got_a[0] !== 32'hFFFF_FFFC || got_a[1] !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h %h expected FFFFFFFC 00000000", got_a[0], got_a[1]); end
    n_checks++; if (got_data !== 32'h3344_AABB) begin n_fail++; $display("FAIL wrap_data: got %h expected 3344AABB", got_data); end
  endtask

  task automatic test_reject();
    run_load(1'b1, 32'h200, 2'b10, 1'b0);
    n_checks++; if (got_data !== 32'h4433_2211 || got_mis !== 1'b0) begin n_fail++; $display("FAIL nosplit_aligned: got %h/%b expected 44332211/0", got_data, got_mis); end
    run_load(1'b1, 32'h203, 2'b10, 1'b0);
    n_checks++; if (got_mis !== 1'b1 || got_data !== 32'h0) begin n_fail++; $display("FAIL reject_mis_word: got %b/%h expected 1/00000000", got_mis, got_data); end
    n_checks++; if (got_rdc !== 0 || got_lat !== 1) begin n_fail++; $display("FAIL reject_no_read: got %0d rd cycles, latency %0d expected 0, 1", got_rdc, got_lat); end
    run_load(1'b1, 32'h100, 2'b11, 1'b0);
    n_checks++; if (got_mis !== 1'b1 || got_data !== 32'h0 || got_rdc !== 0) begin n_fail++; $display("FAIL reject_double: got %b/%h/%0d expected 1/00000000/0", got_mis, got_data, got_rdc); end
    run_load(1'b1, 32'h101, 2'b01, 1'b0);
    n_checks++; if (got_mis !== 1'b1) begin n_fail++; $display("FAIL reject_mis_half: got %b expected 1", got_mis); end
  endtask

  task automatic test_back_to_back();
    mem100 = 32'h8000_1234;
    run_load(1'b0, 32'h204, 2'b10, 1'b0);
    run_load(1'b0, 32'h100, 2'b00, 1'b0);
    n_checks++; if (got_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", got_ready); end
    n_checks++; if (got_data !== 32'h34 || got_lat !== 2) begin n_fail++; $display("FAIL b2b_second: got %h lat %0d expected 00000034 lat 2", got_data, got_lat); end
  endtask

  task automatic test_stall();
    int pulses;
    logic [31:0] d;
    mem100 = 32'hCAFE_0001;
    @(negedge clk);
    hold = 1'b1;
    if1.req_valid = 1'b1; if1.req_addr = 32'h100; if1.req_size = 2'b10; if1.req_signed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({if1.req_ready, if1.mem_rd, if1.load_valid} !== 3'b010 || if1.mem_addr !== 32'h100) begin n_fail++; $display("FAIL stall_hold%0d: got rdy/rd/lv %b addr %h expected 010 addr 00000100", i, {if1.req_ready, if1.mem_rd, if1.load_valid}, if1.mem_addr); end
    end
    hold = 1'b0;
    if1.req_valid = 1'b0;
    pulses = 0;
    d = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if1.load_valid) begin pulses++; d = if1.load_data; end
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL stall_pulses: got %0d expected 1", pulses); end
    n_checks++; if (d !== 32'hCAFE_0001) begin n_fail++; $display("FAIL stall_data: got %h expected CAFE0001", d); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    if1.req_valid = 1'b1; if1.req_addr = 32'h203; if1.req_size = 2'b10; if1.req_signed = 1'b0;
    @(negedge clk);
    if1.req_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (if1.mem_rd !== 1'b1 || if1.mem_addr !== 32'h204) begin n_fail++; $display("FAIL mid_in_rd1: got rd %b addr %h expected 1 00000204", if1.mem_rd, if1.mem_addr); end
    hold = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if ({if1.req_ready, if1.mem_rd, if1.load_valid, if1.load_misalign} !== 4'b1000 || if1.mem_addr !== 32'h0 || if1.load_data !== 32'h0) begin n_fail++; $display("FAIL mid_reset_vals: got %b %h %h expected 1000 00000000 00000000", {if1.req_ready, if1.mem_rd, if1.load_valid, if1.load_misalign}, if1.mem_addr, if1.load_data); end
    reset = 1'b0;
    hold = 1'b0;
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({if1.req_ready, if1.mem_rd, if1.load_valid} !== 3'b100) begin n_fail++; $display("FAIL late_valid_ignored: got %b expected 100", {if1.req_ready, if1.mem_rd, if1.load_valid}); end
    run_load(1'b0, 32'h200, 2'b10, 1'b0);
    n_checks++; if (got_data !== 32'h4433_2211 || got_lat !== 2) begin n_fail++; $display("FAIL after_reset_load: got %h lat %0d expected 44332211 lat 2", got_data, got_lat); end
  endtask

  initial begin
    if1.req_valid = 1'b0; if1.req_addr = 32'h0; if1.req_size = 2'b00; if1.req_signed = 1'b0;
    if0.req_valid = 1'b0; if0.req_addr = 32'h0; if0.req_size = 2'b00; if0.req_signed = 1'b0;
    test_reset();
    test_byte();
    test_half();
    test_split();
    test_reject();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Parametrised successor to the combinational load-size stage of the multicycle datapath.
- Accepts one load request at a time (address, size, signedness) and issues one or two word reads to data memory.
- Extracts the addressed byte, half, word or double from the returned data, zero- or sign-extends it to DATA_W, and presents it with a one-cycle valid pulse.
- Misaligned accesses are either split across two memory words or flagged, depending on SPLIT_EN.

Parameters:
- DATA_W, 32, memory word and result width in bits; legal values 32 or 64; NB = DATA_W/8 bytes, OB = log2(NB).
- ADDR_W, 32, byte-address width.
- SPLIT_EN, 1, 1 = misaligned loads spanning two words are performed with two reads; 0 = any misaligned load is flagged.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit idle and able to accept a request.
- req_addr  in  ADDR_W  byte address of the load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double (double legal only when DATA_W=64).
- req_signed  in  1  1 = sign-extend, 0 = zero-extend.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  word-aligned read address; low OB bits always 0.
- mem_valid  in  1  mem_rdata valid this cycle.
- mem_rdata  in  DATA_W  memory read data, little-endian byte order.
- load_valid  out  1  one-cycle pulse when the result is available.
- load_data  out  DATA_W  extended load result.
- load_misalign  out  1  qualified by load_valid; 1 = access rejected, no memory read performed.

Behaviour:
- Reset: state IDLE; req_ready=1; mem_rd=0; mem_addr=0; load_valid=0; load_data=0; load_misalign=0; captured words cleared.
- Reset asserted in any state returns to IDLE on the next edge. A mem_valid arriving after reset is ignored.
- States: IDLE, RD0, RD1, DONE. req_ready=1 only in IDLE.
- Accept: in IDLE, a cycle with req_valid=1 latches addr, size and signed. Derived values:
  - bytes = 1<<size.
  - off = addr[OB-1:0].
  - mis = (off mod bytes) != 0.
  - span = (off + bytes) > NB.
- Reject: if size is illegal, or (mis and SPLIT_EN=0), go IDLE -> DONE with load_misalign=1, load_data=0, and no mem_rd.
- RD0:
  - Outputs: mem_rd=1; mem_addr = addr with low OB bits cleared.
  - Holds until mem_valid=1, then captures word0.
  - Next state: RD1 if span, else DONE.
- RD1:
  - Outputs: mem_rd=1; mem_addr = word0 address + NB, modulo 2^ADDR_W (wraps to 0).
  - Holds until mem_valid=1, then captures word1 and moves to DONE.
  - span with SPLIT_EN=0 is unreachable, because span implies mis.
- mem_addr is stable while mem_rd=1. mem_valid is ignored outside RD0 and RD1.
- DONE:
  - load_valid=1 for exactly one cycle, then IDLE.
  - load_data and load_misalign hold their values until the next DONE, or until reset.
- Extraction:
  - cat = {word1, word0} (2*DATA_W bits; word1 = 0 if not read).
  - sel = (cat >> 8*off) truncated to 8*bytes bits.
  - result = sel extended to DATA_W, with sign bit sel[8*bytes-1] when req_signed=1.
  - Double and word loads at full width need no extension.
- Latency: with zero-wait memory (mem_valid in the same cycle as mem_rd):
  - Single read: accept at cycle T, RD0 at T+1, load_valid at T+2.
  - Split read: load_valid at T+3.
  - Each wait cycle on mem_valid adds one cycle.
- Back-to-back requests: the next request can be accepted in the cycle after DONE.

Test Plan:
- Byte loads, DATA_W=32, mem[0x100]=0x8BADF00D, req_addr=0x103, size=00:
  - signed: one read at 0x100, load_data=0xFFFFFF8B.
  - unsigned: load_data=0x0000008B.
  - load_misalign=0 in both cases.
- Half loads, mem[0x100]=0x80001234:
  - half signed at 0x102: load_data=0xFFFF8000.
  - half unsigned at 0x100: load_data=0x00001234.
- Split word load, SPLIT_EN=1, mem[0x200]=0x44332211, mem[0x204]=0x88776655, word load at 0x203:
  - reads at 0x200 then 0x204, load_data=0x77665544, latency T+3 with zero-wait memory.
- Address wrap, SPLIT_EN=1: word load at 0xFFFFFFFE:
  - second mem_addr is 0x00000000.
- Rejects, SPLIT_EN=0:
  - word load at 0x203: no mem_rd, load_valid pulse with load_misalign=1, load_data=0.
  - size=11 with DATA_W=32: same response.
- Memory stall: mem_valid delayed 3 cycles in RD0 while req_valid is held high:
  - req_ready=0, mem_rd=1 and mem_addr constant throughout.
  - exactly one load_valid pulse.
- Reset mid-operation: reset asserted in RD1:
  - next cycle all outputs at reset values.
  - a late mem_valid is ignored.
  - the following aligned word load returns the correct data.
